led_pulse_stretcher: RTL and testbench

// Output-side counterpart of the input debouncer. It takes short, possibly bursty trigger

---
 rtl/led_pulse_stretcher_pkg.sv | 24 ++
 rtl/led_pulse_stretcher_timer.sv | 54 +++++
 rtl/led_pulse_stretcher.sv | 152 +++++++++++++++
 tb/tb_led_pulse_stretcher.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/led_pulse_stretcher_pkg.sv
// -----------------------------------------------------------------------------
// led_pulse_stretcher_pkg
//   Shared definitions for the LED output stage and the input debounce stage:
//   the phase encoding, default timing constants and a small helper used to
//   size counters.
// -----------------------------------------------------------------------------
package led_pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int N_DEFAULT          = 20;
    localparam int HOLD_TICKS_DEFAULT = 3;
    localparam int GAP_TICKS_DEFAULT  = 3;
    localparam int CNT_W_DEFAULT      = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_pulse_stretcher_timer.sv
// -----------------------------------------------------------------------------
// stretch_timer
//   Phase timer: an N-bit prescaler producing a tick every 2**N cycles and a
//   tick counter. done pulses for one cycle on the tick where the tick count
//   equals limit-1, i.e. after exactly limit*2**N cycles since restart.
//
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   restart  in   reload prescaler and tick count to 0 on the next edge
//   limit    in   phase length in ticks (>=1)
//   done     out  one-cycle pulse on the final cycle of the phase
// -----------------------------------------------------------------------------
module stretch_timer #(
    parameter int N       = 20,
    parameter int LIMIT_W = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               restart,
    input  logic [LIMIT_W-1:0] limit,
    output logic               done
);

    logic [N-1:0]       pre_q, pre_d;
    logic [LIMIT_W-1:0] tick_q, tick_d;
    logic               pre_wrap;

    assign pre_wrap = &pre_q;
    assign done     = pre_wrap && (tick_q == (limit - LIMIT_W'(1)));

    always_comb begin
        pre_d  = pre_q + N'(1);
        tick_d = tick_q;
        if (pre_wrap) begin
            tick_d = tick_q + LIMIT_W'(1);
        end
        if (restart) begin
            pre_d  = '0;
            tick_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q  <= '0;
            tick_q <= '0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/led_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// led_pulse_stretcher
//   Turns short trigger pulses into an LED level with a guaranteed minimum ON
//   time (HOLD_TICKS ticks) and minimum OFF gap (GAP_TICKS ticks). One trigger
//   arriving while busy is queued; further ones are merged and counted.
//
// Ports
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   trig        in   trigger request, sampled every cycle
//   clr_cnt     in   synchronous clear of merged_cnt (wins over increment)
//   led         out  stretched LED drive, registered
//   busy        out  1 while in ON or GAP, registered
//   merged_cnt  out  saturating count of triggers absorbed without own ON
// -----------------------------------------------------------------------------
module led_pulse_stretcher
    import led_pulse_stretcher_pkg::*;
#(
    parameter int N          = N_DEFAULT,
    parameter int HOLD_TICKS = HOLD_TICKS_DEFAULT,
    parameter int GAP_TICKS  = GAP_TICKS_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             trig,
    input  logic             clr_cnt,
    output logic             led,
    output logic             busy,
    output logic [CNT_W-1:0] merged_cnt
);

    localparam int LIMIT_W = $clog2(max_int(HOLD_TICKS, GAP_TICKS) + 1);

    state_e             state_q, state_d;
    logic               pending_q, pending_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               led_q, led_d;
    logic               busy_q, busy_d;
    logic               restart;
    logic               done;
    logic               cnt_inc;
    logic               gap_end;
    logic [LIMIT_W-1:0] limit;

    // ON uses the hold length; GAP (and IDLE, where done is ignored) the gap length.
    assign limit   = (state_q == ON) ? LIMIT_W'(HOLD_TICKS) : LIMIT_W'(GAP_TICKS);
    assign gap_end = (state_q == GAP) && done;

    stretch_timer #(
        .N       (N),
        .LIMIT_W (LIMIT_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (restart),
        .limit   (limit),
        .done    (done)
    );

    // State register and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic. restart marks every state entry, including GAP -> ON.
    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = ON;
                    restart = 1'b1;
                end
            end
            ON: begin
                if (done) begin
                    state_d = GAP;
                    restart = 1'b1;
                end
            end
            GAP: begin
                if (done) begin
                    state_d = (pending_q || trig) ? ON : IDLE;
                    restart = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                restart = 1'b1;
            end
        endcase
    end

    // Output logic, computed from the next state so led/busy are registered
    // yet aligned with the state register.
    always_comb begin
        led_d  = (state_d == ON);
        busy_d = (state_d != IDLE);
    end

    // Queue and merge accounting. On the GAP end tick the pending request is
    // consumed by the new ON; a trig on that same tick is merged only when a
    // request was already pending, otherwise it starts the ON itself.
    always_comb begin
        pending_d = pending_q;
        cnt_inc   = 1'b0;
        if (gap_end) begin
            pending_d = 1'b0;
            cnt_inc   = pending_q && trig;
        end else if ((state_q != IDLE) && trig) begin
            if (pending_q) begin
                cnt_inc = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign led        = led_q;
    assign busy       = busy_q;
    assign merged_cnt = cnt_q;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher with N=2, HOLD_TICKS=3, GAP_TICKS=2,
// CNT_W=3: ON lasts 12 cycles and GAP 8 cycles. Scenario cycle numbers are
// relative to a local origin t=0 taken while the DUT is idle; inputs set in
// cycle c are sampled at the edge ending cycle c.
module tb_led_pulse_stretcher;

  localparam int N    = 2;
  localparam int HOLD = 3;
  localparam int GAPT = 2;
  localparam int CW   = 3;

  logic          clk;
  logic          reset_n;
  logic          trig;
  logic          clr_cnt;
  logic          led;
  logic          busy;
  logic [CW-1:0] merged_cnt;

  int t;
  int n_checks;
  int n_pass;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  led_pulse_stretcher #(
    .N          (N),
    .HOLD_TICKS (HOLD),
    .GAP_TICKS  (GAPT),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .trig       (trig),
    .clr_cnt    (clr_cnt),
    .led        (led),
    .busy       (busy),
    .merged_cnt (merged_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0d)", tag, got, exp, t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic goto(input int c);
    while (t < c) step();
  endtask

  task automatic pulse_at(input int c);
    goto(c);
    trig = 1'b1;
    goto(c + 1);
    trig = 1'b0;
  endtask

  task automatic clear_count();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("clr_idle", 32'(merged_cnt), 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    t        = 0;
    trig     = 1'b0;
    clr_cnt  = 1'b0;
    reset_n  = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_led", 32'(led), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(merged_cnt), 0);
    step();
    step();
    reset_n = 1'b1;
    repeat (5) step();
    chk("post_rst_busy", 32'(busy), 0);

    // 1: single pulse at 10
    t = 0;
    pulse_at(10);
    chk("s1_led_lat", 32'(led), 1);
    chk("s1_busy11", 32'(busy), 1);
    goto(22); chk("s1_led22", 32'(led), 1);
    goto(23); chk("s1_led23", 32'(led), 0);
    chk("s1_busy23", 32'(busy), 1);
    goto(30); chk("s1_busy30", 32'(busy), 1);
    goto(31); chk("s1_busy31", 32'(busy), 0);
    chk("s1_cnt", 32'(merged_cnt), 0);

    // 2: extra pulses at 13 and 15 -> one queued, one merged
    t = 0;
    pulse_at(10);
    pulse_at(13);
    pulse_at(15);
    chk("s2_cnt16", 32'(merged_cnt), 1);
    goto(30); chk("s2_led30", 32'(led), 0);
    goto(31); chk("s2_led31", 32'(led), 1);
    goto(42); chk("s2_led42", 32'(led), 1);
    goto(43); chk("s2_led43", 32'(led), 0);
    goto(50); chk("s2_busy50", 32'(busy), 1);
    goto(51); chk("s2_busy51", 32'(busy), 0);
    chk("s2_cnt51", 32'(merged_cnt), 1);

    // 3: trig only on the GAP end tick with nothing pending
    clear_count();
    t = 0;
    pulse_at(10);
    pulse_at(30);
    chk("s3_led31", 32'(led), 1);
    chk("s3_cnt31", 32'(merged_cnt), 0);
    goto(42); chk("s3_led42", 32'(led), 1);
    goto(43); chk("s3_led43", 32'(led), 0);
    goto(52); chk("s3_busy52", 32'(busy), 0);

    // 4: trig held high for 200 cycles -> 12 on / 8 off, count saturates at 7
    t = 0;
    trig = 1'b1;
    for (int c = 1; c < 200; c++) begin
      goto(c);
      chk("s4_led", 32'(led), (((c - 1) % 20) < 12) ? 1 : 0);
      if (c == 60) chk("s4_cnt60", 32'(merged_cnt), 7);
    end
    chk("s4_cnt199", 32'(merged_cnt), 7);
    goto(200);
    trig = 1'b0;
    goto(201); chk("s4_led201", 32'(led), 1);
    goto(213); chk("s4_led213", 32'(led), 0);
    goto(220); chk("s4_busy220", 32'(busy), 1);
    goto(221); chk("s4_busy221", 32'(busy), 0);
    chk("s4_cnt_nowrap", 32'(merged_cnt), 7);

    // 6: clear colliding with an increment from 5
    clear_count();
    t = 0;
    pulse_at(10);
    goto(12);
    trig = 1'b1;
    goto(18);
    trig = 1'b0;
    chk("s6_cnt18", 32'(merged_cnt), 5);
    goto(19);
    trig = 1'b1;
    clr_cnt = 1'b1;
    goto(20);
    trig = 1'b0;
    clr_cnt = 1'b0;
    chk("s6_cnt20", 32'(merged_cnt), 0);
    goto(22); chk("s6_led22", 32'(led), 1);
    goto(23); chk("s6_led23", 32'(led), 0);
    goto(31); chk("s6_led31", 32'(led), 1);
    goto(51); chk("s6_busy51", 32'(busy), 0);
    chk("s6_cnt51", 32'(merged_cnt), 0);

    // 5: reset in the middle of ON with a pending request and nonzero count
    t = 0;
    pulse_at(10);
    pulse_at(13);
    pulse_at(14);
    goto(16);
    chk("s5_cnt16", 32'(merged_cnt), 1);
    chk("s5_led16", 32'(led), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("s5_rst_led", 32'(led), 0);
    chk("s5_rst_busy", 32'(busy), 0);
    chk("s5_rst_cnt", 32'(merged_cnt), 0);
    step();
    step();
    reset_n = 1'b1;
    t = 0;
    goto(40);
    chk("s5_no_pending", 32'(busy), 0);
    pulse_at(41);
    chk("s5_new_led", 32'(led), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
